// File: rtl/icache_refill.sv
// icache_refill: instruction-cache refill engine.
// On a fetch miss it reads four bytes over the 8-bit memory port and packs them
// little-endian into one 32-bit instruction. It then writes that word into the icache
// and hands it to the fetch stage in the same cycle.
module icache_refill #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  fetch_req_i,
    input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
    input  logic                  hit_i,
    input  logic                  flush_i,
    output logic                  fetch_done_o,
    output logic [31:0]           fetch_inst_o,
    output logic                  cache_we_o,
    output logic [ADDR_WIDTH-1:0] cache_waddr_o,
    output logic [31:0]           cache_winst_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [7:0]            mem_byte_i
);

    typedef enum logic [1:0] {IDLE, REQ, READ, WRITE} state_t;

    // The read counter counts READ cycles from 0. Byte k arrives when the counter equals
    // k + LAT, so the last byte arrives when it equals LAT + 3.
    localparam logic [2:0] LAT      = 3'(READ_LATENCY);
    localparam logic [2:0] LAST_CNT = 3'(READ_LATENCY + 3);

    state_t                state;
    logic [ADDR_WIDTH-1:0] base;
    logic [2:0]            read_cnt;
    logic [23:0]           low_bytes;
    logic [1:0]            cap_idx;
    logic [1:0]            next_off;
    logic                  unused_addr_bits;

    // Fetch addresses are word aligned, so the two low bits carry no information here.
    assign unused_addr_bits = ^fetch_addr_i[1:0];

    // This block works out two values from the read counter.
    // cap_idx is the byte slot that arrives in this cycle.
    // next_off is the word offset to present next. It stops at 3 so the last address holds.
    always_comb begin
        cap_idx  = 2'(read_cnt - LAT);
        next_off = (read_cnt >= 3'd2) ? 2'd3 : 2'(read_cnt + 3'd1);
    end

    // Refill state machine. Every output is a register. Reset wins over everything else,
    // and rdy low freezes the whole engine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            base          <= '0;
            read_cnt      <= '0;
            low_bytes     <= '0;
            fetch_done_o  <= 1'b0;
            fetch_inst_o  <= '0;
            cache_we_o    <= 1'b0;
            cache_waddr_o <= '0;
            cache_winst_o <= '0;
            mem_req_o     <= 1'b0;
            mem_addr_o    <= '0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (fetch_req_i && !hit_i && !flush_i) begin
                        base      <= {fetch_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        mem_req_o <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (flush_i) begin
                        mem_req_o <= 1'b0;
                        state     <= IDLE;
                    end else if (mem_gnt_i) begin
                        mem_addr_o <= base;
                        read_cnt   <= '0;
                        state      <= READ;
                    end
                end
                READ: begin
                    if (flush_i) begin
                        mem_req_o <= 1'b0;
                        low_bytes <= '0;
                        read_cnt  <= '0;
                        state     <= IDLE;
                    end else begin
                        mem_addr_o <= base + ADDR_WIDTH'(next_off);
                        read_cnt   <= read_cnt + 3'd1;
                        if (read_cnt == LAST_CNT) begin
                            fetch_inst_o  <= {mem_byte_i, low_bytes};
                            cache_winst_o <= {mem_byte_i, low_bytes};
                            cache_waddr_o <= base;
                            cache_we_o    <= 1'b1;
                            fetch_done_o  <= 1'b1;
                            mem_req_o     <= 1'b0;
                            state         <= WRITE;
                        end else if (read_cnt >= LAT) begin
                            case (cap_idx)
                                2'd0:    low_bytes[7:0]   <= mem_byte_i;
                                2'd1:    low_bytes[15:8]  <= mem_byte_i;
                                2'd2:    low_bytes[23:16] <= mem_byte_i;
                                default: low_bytes        <= low_bytes;
                            endcase
                        end
                    end
                end
                WRITE: begin
                    cache_we_o   <= 1'b0;
                    fetch_done_o <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill.
// Two instances run from one stimulus: dut_a uses READ_LATENCY=1 and dut_b uses
// READ_LATENCY=2. Each instance is fed by its own pipelined byte memory.
// Expected words, addresses and pulse timing come from a transaction-level model of the
// refill rules.
module tb_icache_refill;

    logic        clk = 1'b0;
    logic        rst, rdy, fetch_req, hit, flush, gnt, sel;
    logic [31:0] fetch_addr;

    logic        done_a, we_a, req_a, done_b, we_b, req_b;
    logic [31:0] inst_a, waddr_a, winst_a, maddr_a, inst_b, waddr_b, winst_b, maddr_b;
    logic [7:0]  byte_a, byte_b, pipe_a, pipe_b0, pipe_b1;

    logic        o_done, o_we, o_req;
    logic [31:0] o_inst, o_waddr, o_winst, o_maddr;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem_init [logic [31:0]];

    always #5 clk = ~clk;

    icache_refill #(.READ_LATENCY(1), .ADDR_WIDTH(32)) dut_a (
        .clk(clk), .rst(rst), .rdy(rdy),
        .fetch_req_i(fetch_req & ~sel), .fetch_addr_i(fetch_addr), .hit_i(hit), .flush_i(flush),
        .fetch_done_o(done_a), .fetch_inst_o(inst_a), .cache_we_o(we_a),
        .cache_waddr_o(waddr_a), .cache_winst_o(winst_a), .mem_req_o(req_a),
        .mem_gnt_i(gnt & ~sel), .mem_addr_o(maddr_a), .mem_byte_i(byte_a)
    );

    icache_refill #(.READ_LATENCY(2), .ADDR_WIDTH(32)) dut_b (
        .clk(clk), .rst(rst), .rdy(rdy),
        .fetch_req_i(fetch_req & sel), .fetch_addr_i(fetch_addr), .hit_i(hit), .flush_i(flush),
        .fetch_done_o(done_b), .fetch_inst_o(inst_b), .cache_we_o(we_b),
        .cache_waddr_o(waddr_b), .cache_winst_o(winst_b), .mem_req_o(req_b),
        .mem_gnt_i(gnt & sel), .mem_addr_o(maddr_b), .mem_byte_i(byte_b)
    );

    // Backing store: explicit entries first, otherwise a fixed hash of the address.
    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem_init.exists(a)) return mem_init[a];
        return (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    // This block models the memory read delay for each instance: one stage for dut_a,
    // two stages for dut_b. The memory stalls together with the engine while rdy is low.
    always @(posedge clk) begin
        if (rdy) begin
            pipe_a  <= mem_rd(maddr_a);
            pipe_b0 <= mem_rd(maddr_b);
            pipe_b1 <= pipe_b0;
        end
    end
    assign byte_a = pipe_a;
    assign byte_b = pipe_b1;

    // This block routes the outputs of the instance under test to one set of observation signals.
    assign o_done  = sel ? done_b  : done_a;
    assign o_we    = sel ? we_b    : we_a;
    assign o_req   = sel ? req_b   : req_a;
    assign o_inst  = sel ? inst_b  : inst_a;
    assign o_waddr = sel ? waddr_b : waddr_a;
    assign o_winst = sel ? winst_b : winst_a;
    assign o_maddr = sel ? maddr_b : maddr_a;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req_v, input logic [31:0] addr_v,
                                 input logic hit_v, input logic flush_v, input logic gnt_v);
        fetch_req  = req_v;
        fetch_addr = addr_v;
        hit        = hit_v;
        flush      = flush_v;
        gnt        = gnt_v;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One refill on the selected instance, checked against the refill rules.
    // stall_at is the READ-cycle index at which rdy drops for stall_len cycles.
    // flush_at is the READ-cycle index at which flush_i is pulsed. Use -1 to disable either one.
    task automatic run_miss(input logic [31:0] addr, input int gnt_delay,
                            input int stall_at, input int stall_len, input int flush_at);
        logic [31:0] base, exp_word, snap;
        int lat, i, n, stalled;
        bit finished;
        lat      = sel ? 2 : 1;
        base     = {addr[31:2], 2'b00};
        exp_word = {mem_rd(base + 32'd3), mem_rd(base + 32'd2), mem_rd(base + 32'd1), mem_rd(base)};
        applyStimulus(1'b1, addr, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, $urandom, 1'b0, 1'b0, 1'b0);
        checkOutput("req_raised", o_req, 1);
        snap = o_maddr;
        for (int d = 0; d < gnt_delay; d++) begin
            checkOutput("gnt_wait_addr", o_maddr, snap);
            checkOutput("gnt_wait_req", o_req, 1);
            tick();
        end
        gnt = 1'b1;
        tick();
        i = 0; n = 0; stalled = 0; finished = 1'b0;
        while (!finished && n < 40) begin
            if (i == flush_at) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
                gnt   = 1'b0;
                checkOutput("flush_req_drop", o_req, 0);
                checkOutput("flush_no_we", o_we, 0);
                checkOutput("flush_no_done", o_done, 0);
                tick();
                checkOutput("flush_still_idle", o_req | o_we | o_done, 0);
                return;
            end
            if (i == stall_at && stalled == 0 && stall_len > 0) begin
                snap = o_maddr;
                rdy  = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    n++;
                    checkOutput("stall_addr", o_maddr, snap);
                    checkOutput("stall_req", o_req, 1);
                    checkOutput("stall_done", o_done, 0);
                end
                rdy     = 1'b1;
                stalled = stall_len;
            end
            if (o_done) begin
                finished = 1'b1;
            end else begin
                checkOutput("read_addr", o_maddr, base + ((i < 3) ? i : 3));
                checkOutput("read_req", o_req, 1);
                tick();
                i++;
                n++;
            end
        end
        gnt = 1'b0;
        checkOutput("done_seen", finished, 1);
        checkOutput("done_cycles", n, 4 + lat + stalled);
        checkOutput("write_we", o_we, 1);
        checkOutput("write_waddr", o_waddr, base);
        checkOutput("write_winst", o_winst, exp_word);
        checkOutput("write_inst", o_inst, exp_word);
        checkOutput("write_req_low", o_req, 0);
        tick();
        checkOutput("after_done_low", o_done, 0);
        checkOutput("after_we_low", o_we, 0);
        checkOutput("after_inst_hold", o_inst, exp_word);
    endtask

    initial begin
        logic [31:0] snap;
        int sa;
        sel = 1'b0;
        rst = 1'b1;
        rdy = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            checkOutput("reset_done", o_done, 0);
            checkOutput("reset_we", o_we, 0);
            checkOutput("reset_req", o_req, 0);
            checkOutput("reset_maddr", o_maddr, 0);
            checkOutput("reset_inst", o_inst, 0);
        end
        sel = 1'b0;

        $display("[TB] hit is ignored");
        applyStimulus(1'b1, 32'h1000, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("hit_no_activity", o_req | o_we | o_done, 0);
        end

        $display("[TB] flush in IDLE blocks start");
        applyStimulus(1'b1, 32'h1000, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("idle_flush_blocks", o_req, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("[TB] basic miss");
        mem_init[32'h1000] = 8'h13;
        mem_init[32'h1001] = 8'h05;
        mem_init[32'h1002] = 8'h00;
        mem_init[32'h1003] = 8'h00;
        run_miss(32'h1000, 0, -1, 0, -1);
        checkOutput("basic_word", o_inst, 32'h0000_0513);

        $display("[TB] delayed grant, unaligned fetch address");
        run_miss(32'h2006, 3, -1, 0, -1);

        $display("[TB] flush mid READ then clean refill");
        run_miss(32'h1000, 0, -1, 0, 3);
        run_miss(32'h3000, 0, -1, 0, -1);

        $display("[TB] rdy stall mid READ");
        run_miss(32'h1000, 0, 2, 5, -1);
        checkOutput("stall_word", o_inst, 32'h0000_0513);

        $display("[TB] READ_LATENCY=2 basic miss");
        sel = 1'b1;
        run_miss(32'h1000, 0, -1, 0, -1);
        checkOutput("lat2_word", o_inst, 32'h0000_0513);

        $display("[TB] randomized refills");
        for (int r = 0; r < 10; r++) begin
            sel = 1'($urandom_range(0, 1));
            sa  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4)) : -1;
            run_miss((r == 0) ? 32'hFFFF_FFFE : $urandom, int'($urandom_range(0, 3)),
                     sa, int'($urandom_range(1, 4)), -1);
        end

        $display("[TB] synchronous reset in READ");
        sel = 1'b0;
        applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 1'b1);
        tick();
        fetch_req = 1'b0;
        tick();
        tick();
        tick();
        snap = o_maddr;
        checkOutput("pre_reset_addr", snap, 32'h1002);
        rst = 1'b1;
        rdy = 1'b0;
        #2;
        checkOutput("reset_no_edge_addr", o_maddr, snap);
        checkOutput("reset_no_edge_req", o_req, 1);
        tick();
        checkOutput("reset_read_req", o_req, 0);
        checkOutput("reset_read_maddr", o_maddr, 0);
        checkOutput("reset_read_inst", o_inst, 0);
        checkOutput("reset_read_winst", o_winst, 0);
        checkOutput("reset_read_waddr", o_waddr, 0);
        checkOutput("reset_read_pulses", o_we | o_done, 0);
        rst = 1'b0;
        rdy = 1'b1;
        gnt = 1'b0;
        tick();
        run_miss(32'h1000, 1, -1, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
